mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request-side controller that sits directly upstream of the single-port data memory. It turns a valid/ready request stream (reads and writes) into single-cycle memory strobes, and collects the memory's one-cycle-latency read data into a response FIFO with valid/ready backpressure. It drops out-of-range accesses, and it checks that the memory returns read data exactly when expected.

## Interface
- DM_AW, 10, memory address width
- DM_DW, 32, memory data width
- RAM_DEPTH, 1<<DM_AW, number of physical words; addresses >= RAM_DEPTH are out of range
- RSP_DEPTH, 4, response FIFO depth (power of 2, >= 2)

- clk  in  1  clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  DM_AW  request address
- req_wdata  in  DM_DW  write data
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_data  out  DM_DW  read data (zero when rsp_err)
- rsp_err  out  1  response belongs to an out-of-range read
- mem_addr  out  DM_AW  memory address, registered
- mem_wdata  out  DM_DW  memory write data, registered
- mem_wr_en  out  1  memory write strobe, registered
- mem_rd_en  out  1  memory read strobe, registered
- mem_rdata  in  DM_DW  memory read data
- mem_rdata_vld  in  1  memory read data valid (one cycle after mem_rd_en)
- proto_err  out  1  sticky: mem_rdata_vld disagreed with expectation

## Operation
- Accept: a request is accepted in any cycle where req_vld & req_rdy.
- Ready: req_rdy = !rst & (fifo_count + pipe_reads < RSP_DEPTH).
  - pipe_reads counts accepted reads not yet pushed into the FIFO (0..2).
  - Reads and writes are both gated, so req_rdy never depends on the payload.
- In-range write: the next cycle drives mem_wr_en=1, mem_addr, mem_wdata. No response is generated.
- Out-of-range write (addr >= RAM_DEPTH): silently dropped. No strobe, no response.
- In-range read: the next cycle drives mem_rd_en=1 and mem_addr. mem_wdata holds its last value.
- Out-of-range read: no strobe. The read still travels the 2-stage tag pipe and produces a response with rsp_err=1 and rsp_data=0.
- Tag pipe:
  - Stage 1 = {vld, err} registered at accept.
  - Stage 2 = stage 1 delayed one cycle.
  - When stage 2 is valid, the FIFO pushes {err ? 0 : mem_rdata, err}.
- Response FIFO:
  - Registered RSP_DEPTH-entry circular buffer with wrapping read/write pointers and a count of width clog2(RSP_DEPTH)+1.
  - Pop on rsp_vld & rsp_rdy.
  - Push and pop in the same cycle leaves the count unchanged.
  - Overflow is impossible by construction of req_rdy.
- Protocol check:
  - expected = stage 2 valid & !stage 2 err.
  - If mem_rdata_vld != expected in any non-reset cycle, proto_err is set and held until rst.
- Only one memory strobe per cycle; wr_en and rd_en are never both 1.

## Timing
- Reset (rst=1 at a clk edge) clears:
  - all mem_* outputs to 0,
  - the tag pipe,
  - FIFO pointers and count,
  - rsp_vld=0, rsp_data=0, rsp_err=0, proto_err=0.
- req_rdy is 0 while rst=1. Reset must be held >= 2 cycles so the memory's read-valid flop drains.
- Reset mid-operation discards in-flight reads and queued responses. No response is emitted for them.
- Read latency: accept at cycle A → mem_rd_en in A+1 → mem_rdata_vld in A+2 → rsp_vld in A+3 (if FIFO empty).
- Write: accept at A → mem_wr_en in A+1 only.
- Throughput: one request per cycle while rsp_rdy=1.
  - With rsp_rdy=0, at most RSP_DEPTH reads are accepted, then req_rdy=0.
  - req_rdy reasserts the cycle after the first pop frees a slot.
- rsp_data and rsp_err are stable while rsp_vld & !rsp_rdy.
- Responses are returned in request order, including error responses.

## Test plan
- Write 0xDEADBEEF to addr 5, then read addr 5 with rsp_rdy=1:
  - mem_wr_en pulses 1 cycle after the write is accepted;
  - rsp_vld appears 3 cycles after the read is accepted, with rsp_data=0xDEADBEEF and rsp_err=0.
- Back-to-back reads of addrs 0..7 (preloaded with addr*3) with rsp_rdy=0 and RSP_DEPTH=4:
  - exactly 4 are accepted, then req_rdy=0;
  - raising rsp_rdy drains 0,3,6,9 in order, then the remaining 4 follow;
  - no drops, no proto_err.
- With RAM_DEPTH=512, read addr 600 between reads of addrs 1 and 2:
  - no mem_rd_en for 600;
  - responses arrive in order (data@1, {0,err=1}, data@2).
- With RAM_DEPTH=512, write addr 700:
  - no mem_wr_en, no response;
  - a subsequent read of 700 returns err=1.
- Force a spurious mem_rdata_vld=1 with no read pending: proto_err rises next cycle and stays 1 until rst.
- Assert rst for 2 cycles with 3 responses queued and 1 read in flight:
  - all outputs return to 0; no stale response appears afterwards;
  - a new read returns correct data with proto_err=0.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: turns a valid/ready request stream into single-cycle strobes for the data
// memory, and queues the one-cycle-latency read data in an in-order response FIFO.

module mem_req_ctrl_chk #(
    parameter int RSP_DEPTH = 4,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_wr_en,
    input  logic          mem_rd_en,
    input  logic          push,
    input  logic          pop,
    input  logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);

    a_one_strobe:   assert property (@(posedge clk) disable iff (rst) !(mem_wr_en && mem_rd_en));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == FULL)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && (count == {CW{1'b0}})));
    a_count_range:  assert property (@(posedge clk) disable iff (rst) (count <= FULL));
endmodule

module mem_req_ctrl #(
    parameter int DM_AW     = 10,
    parameter int DM_DW     = 32,
    parameter int RAM_DEPTH = 32'd1 << DM_AW,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_wr,
    input  logic [DM_AW-1:0] req_addr,
    input  logic [DM_DW-1:0] req_wdata,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [DM_DW-1:0] rsp_data,
    output logic             rsp_err,
    output logic [DM_AW-1:0] mem_addr,
    output logic [DM_DW-1:0] mem_wdata,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    input  logic [DM_DW-1:0] mem_rdata,
    input  logic             mem_rdata_vld,
    output logic             proto_err
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DM_DW + 1;
    localparam logic [DM_AW:0] RAM_LIMIT  = (DM_AW + 1)'(RAM_DEPTH);
    localparam logic [CW:0]    SLOT_LIMIT = (CW + 1)'(RSP_DEPTH);

    function automatic logic addr_in_range(input logic [DM_AW-1:0] addr);
        return ({1'b0, addr} < RAM_LIMIT);
    endfunction

    // FIFO entry layout is {data, err}; error entries always carry zero data.
    function automatic logic [EW-1:0] rsp_entry(input logic [DM_DW-1:0] data, input logic err);
        return err ? {{DM_DW{1'b0}}, 1'b1} : {data, 1'b0};
    endfunction

    logic              accept_s;
    logic              in_range_s;
    logic              push_s;
    logic              pop_s;
    logic              rd_expected_s;
    logic [CW:0]       occupancy_s;
    logic [EW-1:0]     head_s;

    logic              s1_vld_r;
    logic              s1_err_r;
    logic              s2_vld_r;
    logic              s2_err_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [EW-1:0]     rsp_buf_r [RSP_DEPTH];

    // Handshake, flow control and response-head decode.
    always_comb begin
        occupancy_s   = {1'b0, count_r} + {{CW{1'b0}}, s1_vld_r} + {{CW{1'b0}}, s2_vld_r};
        req_rdy       = !rst && (occupancy_s < SLOT_LIMIT);
        accept_s      = req_vld && req_rdy;
        in_range_s    = addr_in_range(req_addr);
        push_s        = s2_vld_r;
        rd_expected_s = s2_vld_r && !s2_err_r;
        head_s        = rsp_buf_r[rd_ptr_r];
        rsp_vld       = (count_r != {CW{1'b0}});
        pop_s         = rsp_vld && rsp_rdy;
        if (rsp_vld) begin
            rsp_data = head_s[EW-1:1];
            rsp_err  = head_s[0];
        end else begin
            rsp_data = {DM_DW{1'b0}};
            rsp_err  = 1'b0;
        end
    end

    // Memory strobes: out-of-range accesses never reach the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= {DM_AW{1'b0}};
            mem_wdata <= {DM_DW{1'b0}};
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            if (accept_s && in_range_s) begin
                mem_addr <= req_addr;
                if (req_wr) begin
                    mem_wr_en <= 1'b1;
                    mem_wdata <= req_wdata;
                end else begin
                    mem_rd_en <= 1'b1;
                end
            end
        end
    end

    // Two-stage read tag pipe, lined up with the memory's read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r <= 1'b0;
            s1_err_r <= 1'b0;
            s2_vld_r <= 1'b0;
            s2_err_r <= 1'b0;
        end else begin
            s1_vld_r <= accept_s && !req_wr;
            s1_err_r <= accept_s && !req_wr && !in_range_s;
            s2_vld_r <= s1_vld_r;
            s2_err_r <= s1_err_r;
        end
    end

    // Response storage; stale slots are harmless because the pointers govern visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rsp_buf_r[wr_ptr_r] <= rsp_entry(mem_rdata, s2_err_r);
        end
    end

    // Response FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky protocol error: read-data valid must match the tag pipe exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (mem_rdata_vld != rd_expected_s) begin
            proto_err <= 1'b1;
        end
    end

    mem_req_ctrl_chk #(
        .RSP_DEPTH (RSP_DEPTH),
        .CW        (CW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .push      (push_s),
        .pop       (pop_s),
        .count     (count_r)
    );
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a one-cycle-latency memory model attached.

module tb_mem_req_ctrl;
    localparam int DM_AW     = 10;
    localparam int DM_DW     = 32;
    localparam int RAM_DEPTH = 512;
    localparam int RSP_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_vld = 1'b0;
    logic             req_rdy;
    logic             req_wr = 1'b0;
    logic [DM_AW-1:0] req_addr = '0;
    logic [DM_DW-1:0] req_wdata = '0;
    logic             rsp_vld;
    logic             rsp_rdy = 1'b0;
    logic [DM_DW-1:0] rsp_data;
    logic             rsp_err;
    logic [DM_AW-1:0] mem_addr;
    logic [DM_DW-1:0] mem_wdata;
    logic             mem_wr_en;
    logic             mem_rd_en;
    logic [DM_DW-1:0] mem_rdata = '0;
    logic             mem_rdata_vld = 1'b0;
    logic             proto_err;

    logic [DM_DW-1:0] mem_model [1 << DM_AW];
    logic             spur = 1'b0;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int idx;
    int base;
    int seen;

    mem_req_ctrl #(
        .DM_AW(DM_AW), .DM_DW(DM_DW), .RAM_DEPTH(RAM_DEPTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Single-port memory: write in the strobe cycle, read data one cycle later.
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
        mem_rdata_vld <= mem_rd_en | spur;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe counters and strobe exclusivity, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en === 1'b1) rd_cnt++;
            if (mem_wr_en === 1'b1) wr_cnt++;
            check("one_strobe", {63'd0, mem_wr_en & mem_rd_en}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input logic [DM_DW-1:0] d, input logic e);
        int n = 0;
        while (!rsp_vld && n < 20) begin
            step();
            n++;
        end
        check({tag, "_vld"}, rsp_vld, 1'b1);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_err"}, rsp_err, e);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_rdy"}, req_rdy, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 10'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wr_en"}, mem_wr_en, 1'b0);
        check({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
        check({tag, "_rsp_vld"}, rsp_vld, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
        check({tag, "_proto_err"}, proto_err, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("rst0");
        rst = 1'b0;
        step();
        check("rdy_after_rst", req_rdy, 1'b1);

        // Preload addrs 0..7 with addr*3 through the DUT.
        base = wr_cnt;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'(i); req_wdata = 32'(i * 3);
            step();
        end
        req_vld = 1'b0; req_wr = 1'b0;
        repeat (3) step();
        check("preload_wr_cnt", wr_cnt - base, 8);
        check("preload_no_rsp", rsp_vld, 1'b0);

        // Back-to-back reads with the response side stalled.
        rsp_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            req_vld = 1'b1; req_addr = 10'(idx);
            if (req_rdy) idx++;
            step();
        end
        check("b2b_accepted", idx, 4);
        check("b2b_rdy_full", req_rdy, 1'b0);
        check("b2b_head_vld", rsp_vld, 1'b1);
        check("b2b_head_stable", rsp_data, 32'd0);
        rsp_rdy = 1'b1;
        fork
            begin
                step();
                check("b2b_rdy_reassert", req_rdy, 1'b1);
                for (int c = 0; c < 20 && idx < 8; c++) begin
                    req_vld = 1'b1; req_addr = 10'(idx);
                    if (req_rdy) idx++;
                    step();
                end
                req_vld = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) wait_rsp("b2b", 32'(i * 3), 1'b0);
            end
        join
        check("b2b_all_accepted", idx, 8);
        check("b2b_proto", proto_err, 1'b0);

        // Write 0xDEADBEEF to addr 5, then read it back.
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'd5; req_wdata = 32'hDEADBEEF;
        check("wr5_rdy", req_rdy, 1'b1);
        step();
        check("wr5_wr_en", mem_wr_en, 1'b1);
        check("wr5_addr", mem_addr, 10'd5);
        check("wr5_wdata", mem_wdata, 32'hDEADBEEF);
        req_wr = 1'b0;
        step();
        req_vld = 1'b0;
        check("wr5_wr_pulse", mem_wr_en, 1'b0);
        check("rd5_rd_en", mem_rd_en, 1'b1);
        check("rd5_vld_a1", rsp_vld, 1'b0);
        step();
        check("rd5_vld_a2", rsp_vld, 1'b0);
        step();
        check("rd5_vld_a3", rsp_vld, 1'b1);
        check("rd5_data", rsp_data, 32'hDEADBEEF);
        check("rd5_err", rsp_err, 1'b0);
        step();
        check("rd5_popped", rsp_vld, 1'b0);

        // Out-of-range read between two in-range reads.
        base = rd_cnt;
        req_vld = 1'b1;
        req_addr = 10'd1;   check("oor_rdy0", req_rdy, 1'b1); step();
        req_addr = 10'd600; check("oor_rdy1", req_rdy, 1'b1); step();
        req_addr = 10'd2;   check("oor_rdy2", req_rdy, 1'b1); step();
        req_vld = 1'b0;
        wait_rsp("oor_r1", 32'd3, 1'b0);
        wait_rsp("oor_err", 32'd0, 1'b1);
        wait_rsp("oor_r2", 32'd6, 1'b0);
        check("oor_rd_strobes", rd_cnt - base, 2);

        // Out-of-range write is dropped silently.
        base = wr_cnt;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 10'd700; req_wdata = 32'h12345678;
        step();
        req_vld = 1'b0; req_wr = 1'b0;
        check("oorw_wr_en", mem_wr_en, 1'b0);
        repeat (4) step();
        check("oorw_no_rsp", rsp_vld, 1'b0);
        check("oorw_wr_strobes", wr_cnt - base, 0);
        base = rd_cnt;
        req_vld = 1'b1; req_addr = 10'd700;
        step();
        req_vld = 1'b0;
        wait_rsp("oorw_rd", 32'd0, 1'b1);
        check("oorw_rd_strobes", rd_cnt - base, 0);
        check("oor_proto", proto_err, 1'b0);

        // Spurious read-data valid sets a sticky protocol error.
        spur = 1'b1;
        step();
        spur = 1'b0;
        check("spur_before", proto_err, 1'b0);
        step();
        check("spur_set", proto_err, 1'b1);
        repeat (3) step();
        check("spur_sticky", proto_err, 1'b1);

        // Reset with three responses queued and one read in flight.
        rsp_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_vld = 1'b1; req_addr = 10'(i);
            step();
        end
        req_vld = 1'b0;
        step();
        check("pre_rst_vld", rsp_vld, 1'b1);
        rst = 1'b1;
        step();
        step();
        check_all_zero("rst2");
        rst = 1'b0;
        rsp_rdy = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_vld) seen++;
            step();
        end
        check("no_stale_rsp", seen, 0);
        req_vld = 1'b1; req_addr = 10'd5;
        step();
        req_vld = 1'b0;
        wait_rsp("post_rst_rd", 32'hDEADBEEF, 1'b0);
        check("post_rst_proto", proto_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
